req_queue_ctrl: RTL and testbench

Dual request queue between the host command interface and the crypto cores. Each accepted request is routed by opcode into either an AES FIFO or a SHA FIFO. Each FIFO presents its oldest entry to its core through a valid/ready handshake. The two queues are independent, so a stalled core never blocks traffic to the other.

---
 rtl/req_queue_ctrl.sv | 126 ++++++++++++
 tb/tb_req_queue_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/req_queue_ctrl.sv
// Dual request queue: routes host requests by opcode MSB into an AES or SHA FIFO.
// Build macro REQ_QUEUE_COUNT_EN adds count_aes/count_sha occupancy outputs.

module ReqQueueFifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [PW:0]      count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PW:0]      count_q, count_d;

  // Callers only assert push/pop when the queue can accept/supply an entry.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = wrPtr_q + PW'(1);
    if (pop_i) rdPtr_d = rdPtr_q + PW'(1);
    if (push_i && !pop_i) count_d = count_q + (PW+1)'(1);
    else if (pop_i && !push_i) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; the pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i && !reset_i) mem[wrPtr_q] <= data_i;
  end

  assign head_o  = mem[rdPtr_q];
  assign count_o = count_q;

endmodule

module req_queue_ctrl #(
  parameter int ADDRW   = 24,
  parameter int OPCODEW = 2,
  parameter int QDEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  output logic                       ready_in_aes,
  output logic                       ready_in_sha,
  input  logic [OPCODEW-1:0]         opcode,
  input  logic [ADDRW-1:0]           key_addr,
  input  logic [ADDRW-1:0]           text_addr,
  input  logic [ADDRW-1:0]           dest_addr,
  output logic [2*ADDRW+OPCODEW-1:0] instr_aes,
  output logic                       valid_out_aes,
  input  logic                       ready_out_aes,
  output logic [2*ADDRW+OPCODEW-1:0] instr_sha,
  output logic                       valid_out_sha,
  input  logic                       ready_out_sha
`ifdef REQ_QUEUE_COUNT_EN
  ,
  output logic [$clog2(QDEPTH):0]    count_aes,
  output logic [$clog2(QDEPTH):0]    count_sha
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int IW = 2*ADDRW + OPCODEW;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QDEPTH);

  logic [CW-1:0] countAes, countSha;
  logic          toSha, pushAes, pushSha, popAes, popSha;

  // Flow control looks only at registered counts, so no input reaches ready/valid.
  assign ready_in_aes  = (countAes != FULL_COUNT);
  assign ready_in_sha  = (countSha != FULL_COUNT);
  assign valid_out_aes = (countAes != '0);
  assign valid_out_sha = (countSha != '0);

  assign toSha   = opcode[OPCODEW-1];
  assign pushAes = valid_in && !toSha && ready_in_aes;
  assign pushSha = valid_in &&  toSha && ready_in_sha;
  assign popAes  = valid_out_aes && ready_out_aes;
  assign popSha  = valid_out_sha && ready_out_sha;

  ReqQueueFifo #(.WIDTH(IW), .DEPTH(QDEPTH)) aesQueue (
    .clk_i   (clk),
    .reset_i (rst_n),
    .push_i  (pushAes),
    .data_i  ({opcode, key_addr, text_addr}),
    .pop_i   (popAes),
    .head_o  (instr_aes),
    .count_o (countAes)
  );

  ReqQueueFifo #(.WIDTH(IW), .DEPTH(QDEPTH)) shaQueue (
    .clk_i   (clk),
    .reset_i (rst_n),
    .push_i  (pushSha),
    .data_i  ({opcode, text_addr, dest_addr}),
    .pop_i   (popSha),
    .head_o  (instr_sha),
    .count_o (countSha)
  );

`ifdef REQ_QUEUE_COUNT_EN
  assign count_aes = countAes;
  assign count_sha = countSha;
`endif

endmodule

// File: tb/tb_req_queue_ctrl.sv
// Scoreboard bench for req_queue_ctrl: directed pushes feed expected queues,
// a negedge monitor compares every popped head against them.

module tb_req_queue_ctrl;

  localparam int ADDRW   = 24;
  localparam int OPCODEW = 2;
  localparam int QDEPTH  = 16;
  localparam int IW      = 2*ADDRW + OPCODEW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic          ready_in_aes, ready_in_sha;
  logic [1:0]    opcode;
  logic [23:0]   key_addr, text_addr, dest_addr;
  logic [IW-1:0] instr_aes, instr_sha;
  logic          valid_out_aes, valid_out_sha;
  logic          ready_out_aes, ready_out_sha;
`ifdef REQ_QUEUE_COUNT_EN
  logic [4:0]    count_aes, count_sha;
`endif

  logic [IW-1:0] expAes[$];
  logic [IW-1:0] expSha[$];
  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  req_queue_ctrl #(.ADDRW(ADDRW), .OPCODEW(OPCODEW), .QDEPTH(QDEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .ready_in_aes  (ready_in_aes),
    .ready_in_sha  (ready_in_sha),
    .opcode        (opcode),
    .key_addr      (key_addr),
    .text_addr     (text_addr),
    .dest_addr     (dest_addr),
    .instr_aes     (instr_aes),
    .valid_out_aes (valid_out_aes),
    .ready_out_aes (ready_out_aes),
    .instr_sha     (instr_sha),
    .valid_out_sha (valid_out_sha),
    .ready_out_sha (ready_out_sha)
`ifdef REQ_QUEUE_COUNT_EN
    ,
    .count_aes     (count_aes),
    .count_sha     (count_sha)
`endif
  );

  // Monitor: every head handed over at the coming edge must match the oldest expected entry.
  always @(negedge clk) begin : monitorBlk
    logic [IW-1:0] e;
    if (!rst_n) begin
      if (valid_out_aes && ready_out_aes) begin
        checkCount++;
        if (expAes.size() == 0) begin
          errorCount++;
          $display("[TB] FAIL aesPop unexpected entry got %h want none", instr_aes);
        end else begin
          e = expAes.pop_front();
          if (instr_aes !== e) begin
            errorCount++;
            $display("[TB] FAIL aesPop got %h want %h", instr_aes, e);
          end
        end
      end
      if (valid_out_sha && ready_out_sha) begin
        checkCount++;
        if (expSha.size() == 0) begin
          errorCount++;
          $display("[TB] FAIL shaPop unexpected entry got %h want none", instr_sha);
        end else begin
          e = expSha.pop_front();
          if (instr_sha !== e) begin
            errorCount++;
            $display("[TB] FAIL shaPop got %h want %h", instr_sha, e);
          end
        end
      end
    end
  end

  // Direct comparison of a DUT output against a bench-computed value.
  task automatic checkOutput(input string name, input logic [IW-1:0] actual,
                             input logic [IW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  // Drives one request for a cycle; an accepted one becomes expected after the edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [23:0] k,
                               input logic [23:0] t, input logic [23:0] d,
                               input bit accept);
    valid_in  = 1'b1;
    opcode    = op;
    key_addr  = k;
    text_addr = t;
    dest_addr = d;
    @(posedge clk);
    #1;
    if (accept) begin
      if (op[1]) expSha.push_back({op, t, d});
      else       expAes.push_back({op, k, t});
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    valid_in      = 1'b0;
    ready_out_aes = 1'b1;
    ready_out_sha = 1'b1;
    while ((expAes.size() != 0 || expSha.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkCount++;
    if (n >= 100) begin
      errorCount++;
      $display("[TB] FAIL drainTimeout left %0d want 0", expAes.size() + expSha.size());
    end
    checkOutput("aesEmptyAfterDrain", valid_out_aes, 0);
    checkOutput("shaEmptyAfterDrain", valid_out_sha, 0);
    ready_out_aes = 1'b0;
    ready_out_sha = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b1; valid_in = 1'b0; opcode = '0;
    key_addr = '0; text_addr = '0; dest_addr = '0;
    ready_out_aes = 1'b0; ready_out_sha = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetValidAes", valid_out_aes, 0);
    checkOutput("resetValidSha", valid_out_sha, 0);
    checkOutput("resetReadyAes", ready_in_aes, 1);
    checkOutput("resetReadySha", ready_in_sha, 1);
    rst_n = 1'b0;
    idle(1);

    // Single AES request, then single SHA request; heads held while cores stall.
    applyStimulus(2'b00, 24'h111111, 24'h222222, 24'h333333, 1);
    valid_in = 1'b0;
    checkOutput("firstValidAes", valid_out_aes, 1);
    checkOutput("firstInstrAes", instr_aes, {2'b00, 24'h111111, 24'h222222});
    checkOutput("firstValidSha", valid_out_sha, 0);
`ifdef REQ_QUEUE_COUNT_EN
    checkOutput("firstCountAes", count_aes, 1);
`endif
    applyStimulus(2'b10, 24'hAAAAAA, 24'h444444, 24'h555555, 1);
    valid_in = 1'b0;
    checkOutput("firstValidSha2", valid_out_sha, 1);
    checkOutput("firstInstrSha", instr_sha, {2'b10, 24'h444444, 24'h555555});
    checkOutput("aesHeadStable", instr_aes, {2'b00, 24'h111111, 24'h222222});
    drain();

    // Fill the AES queue, try an overflow, keep SHA moving, then pop+push on full.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] op;
      op = (i % 2 == 1) ? 2'b01 : 2'b00;
      applyStimulus(op, 24'h100000 + 24'(i), 24'h200000 + 24'(i), 24'h300000 + 24'(i), 1);
    end
    checkOutput("fullReadyAes", ready_in_aes, 0);
    checkOutput("fullReadySha", ready_in_sha, 1);
    applyStimulus(2'b00, 24'hDEADBE, 24'hEFEFEF, 24'h000000, 0);
    applyStimulus(2'b11, 24'h000000, 24'h777777, 24'h888888, 1);
    checkOutput("stillFullAes", ready_in_aes, 0);
    checkOutput("shaWhileAesFull", valid_out_sha, 1);
    ready_out_aes = 1'b1;
    applyStimulus(2'b00, 24'hBBBBBB, 24'hCCCCCC, 24'hDDDDDD, 0);
    ready_out_aes = 1'b0;
    valid_in = 1'b0;
    checkOutput("readyAfterFullPop", ready_in_aes, 1);
    drain();

    // Streaming through the SHA queue across pointer wrap.
    ready_out_sha = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = (i % 2 == 1) ? 2'b11 : 2'b10;
      applyStimulus(op, 24'h0A0000 + 24'(i), 24'h600000 + 24'(i), 24'h700000 + 24'(i), 1);
      checkOutput("streamReadySha", ready_in_sha, 1);
`ifdef REQ_QUEUE_COUNT_EN
      checkOutput("streamCountSha", count_sha, 1);
`endif
    end
    drain();

    // Reset with five entries queued; a handshake in the reset cycle is ignored.
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b00, 24'h900000 + 24'(i), 24'h910000 + 24'(i), 24'h920000, 1);
    for (int i = 0; i < 2; i++)
      applyStimulus(2'b10, 24'h930000, 24'h940000 + 24'(i), 24'h950000 + 24'(i), 1);
    rst_n = 1'b1;
    ready_out_aes = 1'b1;
    ready_out_sha = 1'b1;
    valid_in = 1'b1;
    opcode = 2'b00;
    key_addr = 24'h123456;
    text_addr = 24'h654321;
    @(posedge clk);
    #1;
    expAes.delete();
    expSha.delete();
    rst_n = 1'b0;
    valid_in = 1'b0;
    checkOutput("midResetValidAes", valid_out_aes, 0);
    checkOutput("midResetValidSha", valid_out_sha, 0);
    checkOutput("midResetReadyAes", ready_in_aes, 1);
    checkOutput("midResetReadySha", ready_in_sha, 1);
    idle(5);
    checkOutput("postResetValidAes", valid_out_aes, 0);
    applyStimulus(2'b01, 24'hABCDEF, 24'hFEDCBA, 24'h000001, 1);
    valid_in = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
